// File: rtl/fetch_debug_ctrl_if.sv
// Debug/load bus between the UART-driven debug sequencer and the fetch stage.
// The master side is the sequencer itself; the slave side is its environment
// (UART receiver, pipeline and instruction memory debug port).
interface fetch_debug_ctrl_if #(
  parameter int NB_CNT = 32
);
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              i_halt;
  logic              o_valid;
  logic              o_cpu_reset;
  logic [15:0]       o_instrmem_addr;
  logic [15:0]       o_instrmem_data;
  logic [3:0]        o_instrmem_we;
  logic              o_instrmem_re;
  logic              o_load_done;
  logic              o_running;
  logic [NB_CNT-1:0] o_cycle_count;

  modport master (
    input  i_rx_data, i_rx_valid, i_halt,
    output o_valid, o_cpu_reset, o_instrmem_addr, o_instrmem_data,
           o_instrmem_we, o_instrmem_re, o_load_done, o_running, o_cycle_count
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_halt,
    input  o_valid, o_cpu_reset, o_instrmem_addr, o_instrmem_data,
           o_instrmem_we, o_instrmem_re, o_load_done, o_running, o_cycle_count
  );
endinterface

// File: rtl/fetch_debug_ctrl.sv
// Debug and load sequencer in front of instruction fetch. Decodes UART command
// bytes, assembles little-endian program words into two halfword writes on the
// debug memory port, gates the pipeline valid for run / single-step, and counts
// executed cycles (saturating).
module fetch_debug_ctrl #(
  parameter int          N_ADDR    = 2048,
  parameter int          NB_CNT    = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic          i_clock,
  input logic          i_reset,
  fetch_debug_ctrl_if.master dbg
);

  localparam logic [7:0]  CMD_LOAD  = 8'h4C;
  localparam logic [7:0]  CMD_RUN   = 8'h52;
  localparam logic [7:0]  CMD_STEP  = 8'h53;
  localparam logic [7:0]  CMD_HALT  = 8'h48;
  localparam logic [15:0] LAST_WORD = 16'(N_ADDR - 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } state_t;

  state_t            state_r;
  logic [15:0]       word_cnt_r;
  logic [1:0]        byte_cnt_r;
  logic [7:0]        byte0_r;
  logic [7:0]        byte2_r;
  logic              lo_flag_r;
  logic              fin_pend_r;
  logic              valid_r;
  logic              cpu_reset_r;
  logic [15:0]       addr_r;
  logic [15:0]       data_r;
  logic [3:0]        we_r;
  logic              re_r;
  logic              load_done_r;
  logic              running_r;
  logic [NB_CNT-1:0] cycle_cnt_r;
  logic              finish_s;

  // Low halfword matches the lower half of the load sentinel.
  function automatic logic is_halt_lo(input logic [15:0] hw);
    return (hw == HALT_WORD[15:0]);
  endfunction

  // Completion is taken one cycle after the final high-half write was issued.
  assign finish_s = (state_r == ST_LOAD) && fin_pend_r;

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      word_cnt_r  <= 16'd0;
      byte_cnt_r  <= 2'd0;
      byte0_r     <= 8'd0;
      byte2_r     <= 8'd0;
      lo_flag_r   <= 1'b0;
      fin_pend_r  <= 1'b0;
      valid_r     <= 1'b0;
      cpu_reset_r <= 1'b0;
      addr_r      <= 16'd0;
      data_r      <= 16'd0;
      we_r        <= 4'b0000;
      re_r        <= 1'b0;
      load_done_r <= 1'b0;
      running_r   <= 1'b0;
    end else begin
      we_r        <= 4'b0000;
      load_done_r <= 1'b0;
      cpu_reset_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          re_r <= 1'b1;
          if (dbg.i_rx_valid) begin
            case (dbg.i_rx_data)
              CMD_LOAD: begin
                state_r    <= ST_LOAD;
                word_cnt_r <= 16'd0;
                byte_cnt_r <= 2'd0;
                fin_pend_r <= 1'b0;
                re_r       <= 1'b0;
              end
              CMD_RUN: begin
                state_r   <= ST_RUN;
                valid_r   <= 1'b1;
                running_r <= 1'b1;
                re_r      <= 1'b0;
              end
              CMD_STEP: begin
                state_r <= ST_STEP;
                valid_r <= 1'b1;
                re_r    <= 1'b0;
              end
              default: begin
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
        ST_LOAD: begin
          if (fin_pend_r) begin
            state_r     <= ST_IDLE;
            fin_pend_r  <= 1'b0;
            load_done_r <= 1'b1;
            cpu_reset_r <= 1'b1;
            re_r        <= 1'b1;
          end else if (dbg.i_rx_valid) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0: byte0_r <= dbg.i_rx_data;
              2'd1: begin
                addr_r    <= word_cnt_r;
                data_r    <= {dbg.i_rx_data, byte0_r};
                we_r      <= 4'b0011;
                lo_flag_r <= is_halt_lo({dbg.i_rx_data, byte0_r});
              end
              2'd2: byte2_r <= dbg.i_rx_data;
              2'd3: begin
                data_r <= {dbg.i_rx_data, byte2_r};
                we_r   <= 4'b1100;
                if ((lo_flag_r && ({dbg.i_rx_data, byte2_r} == HALT_WORD[31:16])) ||
                    (word_cnt_r == LAST_WORD)) begin
                  fin_pend_r <= 1'b1;
                end else begin
                  word_cnt_r <= word_cnt_r + 16'd1;
                end
              end
              default: byte0_r <= byte0_r;
            endcase
          end
        end
        ST_RUN: begin
          if (dbg.i_halt || (dbg.i_rx_valid && (dbg.i_rx_data == CMD_HALT))) begin
            state_r   <= ST_IDLE;
            valid_r   <= 1'b0;
            running_r <= 1'b0;
            re_r      <= 1'b1;
          end
        end
        ST_STEP: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          re_r    <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          valid_r   <= 1'b0;
          running_r <= 1'b0;
          re_r      <= 1'b1;
        end
      endcase
    end
  end

  // Executed-cycle counter: saturating, cleared when a load completes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cycle_cnt_r <= {NB_CNT{1'b0}};
    end else if (finish_s) begin
      cycle_cnt_r <= {NB_CNT{1'b0}};
    end else if (valid_r && (cycle_cnt_r != CNT_MAX)) begin
      cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
    end else begin
      cycle_cnt_r <= cycle_cnt_r;
    end
  end

  assign dbg.o_valid         = valid_r;
  assign dbg.o_cpu_reset     = cpu_reset_r;
  assign dbg.o_instrmem_addr = addr_r;
  assign dbg.o_instrmem_data = data_r;
  assign dbg.o_instrmem_we   = we_r;
  assign dbg.o_instrmem_re   = re_r;
  assign dbg.o_load_done     = load_done_r;
  assign dbg.o_running       = running_r;
  assign dbg.o_cycle_count   = cycle_cnt_r;

endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Randomized self-checking bench for fetch_debug_ctrl. Loads are predicted as
// lists of expected memory writes computed from the byte stream; run/step
// sessions are predicted as numbers of valid cycles and a saturating count.
module tb_fetch_debug_ctrl;
  localparam int          N_ADDR = 4;
  localparam int          NB_CNT = 4;
  localparam int          CNT_SAT = 15;
  localparam logic [31:0] HALT   = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_debug_ctrl_if #(.NB_CNT(NB_CNT)) dbg ();

  fetch_debug_ctrl #(.N_ADDR(N_ADDR), .NB_CNT(NB_CNT), .HALT_WORD(HALT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .dbg     (dbg)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // monitor state
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [3:0]  wr_we_q[$];
  int done_pulses = 0, rst_pulses = 0, pulse_skew = 0;
  int valid_cycles = 0, run_len = 0, last_run_len = 0;

  // model state
  logic [7:0]  load_q[$];
  logic [15:0] ew_addr[$];
  logic [15:0] ew_data[$];
  logic [3:0]  ew_we[$];
  int          exp_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor samples the DUT on the falling edge.
  always @(negedge clk) begin
    if (dbg.o_instrmem_we != 4'b0000) begin
      wr_addr_q.push_back(dbg.o_instrmem_addr);
      wr_data_q.push_back(dbg.o_instrmem_data);
      wr_we_q.push_back(dbg.o_instrmem_we);
    end
    if (dbg.o_load_done) done_pulses++;
    if (dbg.o_cpu_reset) rst_pulses++;
    if (dbg.o_load_done != dbg.o_cpu_reset) pulse_skew++;
    if (dbg.o_valid) begin
      valid_cycles++;
      run_len++;
    end else if (run_len != 0) begin
      last_run_len = run_len;
      run_len = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    dbg.i_rx_data  = b;
    dbg.i_rx_valid = 1'b1;
    tick();
    dbg.i_rx_valid = 1'b0;
    dbg.i_rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  // Expected writes for the data bytes in load_q.
  task automatic model_load();
    ew_addr.delete(); ew_data.delete(); ew_we.delete();
    exp_done = 0;
    for (int w = 0; 4 * w + 1 < load_q.size(); w++) begin
      int i = 4 * w;
      ew_addr.push_back(16'(w)); ew_data.push_back({load_q[i+1], load_q[i]}); ew_we.push_back(4'b0011);
      if (i + 3 >= load_q.size()) break;
      ew_addr.push_back(16'(w)); ew_data.push_back({load_q[i+3], load_q[i+2]}); ew_we.push_back(4'b1100);
      if ({load_q[i+3], load_q[i+2], load_q[i+1], load_q[i]} == HALT || w == N_ADDR - 1) begin
        exp_done = 1;
        break;
      end
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete(); wr_data_q.delete(); wr_we_q.delete();
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr_q.size(), ew_addr.size());
    for (int i = 0; i < ew_addr.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], ew_addr[i]);
      chk($sformatf("%s_data%0d", tag, i), wr_data_q[i], ew_data[i]);
      chk($sformatf("%s_we%0d", tag, i), wr_we_q[i], ew_we[i]);
    end
  endtask

  task automatic run_load(input string tag);
    int d0 = done_pulses;
    int r0 = rst_pulses;
    model_load();
    clear_writes();
    send_byte(8'h4C, $urandom_range(0, 2));
    foreach (load_q[i]) send_byte(load_q[i], $urandom_range(0, 2));
    repeat (4) tick();
    compare_writes(tag);
    chk({tag, "_done"}, done_pulses - d0, exp_done);
    chk({tag, "_cpurst"}, rst_pulses - r0, exp_done);
    if (exp_done == 1) exp_cnt = 0;
    chk({tag, "_cnt"}, dbg.o_cycle_count, exp_cnt);
    chk({tag, "_re"}, dbg.o_instrmem_re, 1);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) load_q.push_back(8'(w >> (8 * b)));
  endtask

  // mode 0: i_halt, 1: 'H' byte, 2: both in the same cycle
  task automatic run_session(input string tag, input int k, input int mode);
    int v0 = valid_cycles;
    int guard = 0;
    send_byte(8'h52, 0);
    while (!dbg.o_valid && guard < 10) begin
      tick();
      guard++;
    end
    chk({tag, "_start"}, (guard < 10), 1);
    if (k >= 2) begin
      tick();
      chk({tag, "_running"}, dbg.o_running, 1);
      repeat (k - 2) tick();
    end
    if (mode != 1) dbg.i_halt = 1'b1;
    if (mode != 0) begin
      dbg.i_rx_data  = 8'h48;
      dbg.i_rx_valid = 1'b1;
    end
    tick();
    dbg.i_halt = 1'b0;
    dbg.i_rx_valid = 1'b0;
    repeat (3) tick();
    exp_cnt = (exp_cnt + k > CNT_SAT) ? CNT_SAT : exp_cnt + k;
    chk({tag, "_vcycles"}, valid_cycles - v0, k);
    chk({tag, "_runlen"}, last_run_len, k);
    chk({tag, "_valid_off"}, dbg.o_valid, 0);
    chk({tag, "_running_off"}, dbg.o_running, 0);
    chk({tag, "_cnt"}, dbg.o_cycle_count, exp_cnt);
  endtask

  task automatic step_once(input string tag);
    int v0 = valid_cycles;
    send_byte(8'h53, 0);
    dbg.i_halt = 1'($urandom);
    tick();
    dbg.i_halt = 1'b0;
    repeat (4) tick();
    exp_cnt = (exp_cnt + 1 > CNT_SAT) ? CNT_SAT : exp_cnt + 1;
    chk({tag, "_vcycles"}, valid_cycles - v0, 1);
    chk({tag, "_runlen"}, last_run_len, 1);
    chk({tag, "_cnt"}, dbg.o_cycle_count, exp_cnt);
  endtask

  task automatic ignored_byte(input string tag, input logic [7:0] b);
    int v0 = valid_cycles;
    clear_writes();
    send_byte(b, 0);
    dbg.i_halt = 1'b1;
    repeat (4) tick();
    dbg.i_halt = 1'b0;
    chk({tag, "_vcycles"}, valid_cycles - v0, 0);
    chk({tag, "_nwr"}, wr_addr_q.size(), 0);
    chk({tag, "_re"}, dbg.o_instrmem_re, 1);
  endtask

  function automatic logic [7:0] rand_noncmd();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53);
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dbg.i_rx_data = 8'h00;
    dbg.i_rx_valid = 1'b0;
    dbg.i_halt = 1'b0;
    tick(); tick();
    chk("rst_valid", dbg.o_valid, 0);
    chk("rst_cpurst", dbg.o_cpu_reset, 0);
    chk("rst_addr", dbg.o_instrmem_addr, 0);
    chk("rst_data", dbg.o_instrmem_data, 0);
    chk("rst_we", dbg.o_instrmem_we, 0);
    chk("rst_re", dbg.o_instrmem_re, 0);
    chk("rst_done", dbg.o_load_done, 0);
    chk("rst_running", dbg.o_running, 0);
    chk("rst_cnt", dbg.o_cycle_count, 0);
    rst = 1'b0;
    tick();
    chk("idle_re", dbg.o_instrmem_re, 1);

    // basic load: 0x12345678 then sentinel
    load_q.delete();
    push_word(32'h12345678); push_word(HALT);
    run_load("load1");

    // low half matches sentinel but high half does not: load continues
    load_q.delete();
    push_word(32'h0000FFFF); push_word($urandom & 32'hFFFFFF00); push_word(HALT);
    run_load("load2");

    run_session("run10", 10, 0);
    run_session("run8", 8, 1);

    // full memory without sentinel, then a trailing non-command byte
    load_q.delete();
    for (int w = 0; w < N_ADDR; w++) push_word({24'($urandom), 8'($urandom_range(0, 254))});
    run_load("loadfull");
    ignored_byte("byte17", rand_noncmd());

    step_once("step1");
    step_once("step2");
    step_once("step3");
    ignored_byte("cmdX", 8'h58);
    ignored_byte("cmdH", 8'h48);

    // reset in the middle of a load
    clear_writes();
    send_byte(8'h4C, 0);
    load_q.delete();
    for (int i = 0; i < 3; i++) load_q.push_back(8'($urandom));
    foreach (load_q[i]) send_byte(load_q[i], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    model_load();
    compare_writes("rstload");
    exp_cnt = 0;
    chk("rstload_re", dbg.o_instrmem_re, 1);
    chk("rstload_cnt", dbg.o_cycle_count, 0);
    chk("rstload_valid", dbg.o_valid, 0);
    load_q.delete();
    push_word($urandom & 32'h7FFFFFFF); push_word(HALT);
    run_load("reload");

    run_session("runboth", 3, 2);

    // randomized mix
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          int nw = $urandom_range(1, N_ADDR);
          load_q.delete();
          for (int w = 0; w < nw - 1; w++) push_word($urandom & 32'hFFFFFF7F);
          push_word((nw == N_ADDR) ? 32'($urandom) : HALT);
          run_load($sformatf("rload%0d", it));
        end
        1: run_session($sformatf("rrun%0d", it), $urandom_range(1, 8), $urandom_range(0, 2));
        2: step_once($sformatf("rstep%0d", it));
        default: ignored_byte($sformatf("rign%0d", it), rand_noncmd());
      endcase
    end

    chk("pulse_align", pulse_skew, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_debug_ctrl.md
Name: fetch_debug_ctrl

Overview:
Debug and load sequencer in front of the instruction fetch stage. It takes a byte stream from the UART receiver and does three jobs:
- assembles program words and writes them into instruction memory through the 16-bit debug write port;
- gates the pipeline valid for continuous or single-step execution;
- counts executed cycles.
It is the only master of the fetch stage's debug memory port and valid input.

Parameters:
N_ADDR, 2048, instruction memory depth in 32-bit words; load terminates after word N_ADDR-1.
NB_CNT, 32, width of executed-cycle counter.
HALT_WORD, 32'hFFFFFFFF, load sentinel; written to memory, then load ends.

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  8  byte from UART receiver
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_halt  in  1  pipeline retired halt instruction (level or pulse)
o_valid  out  1  pipeline advance enable (drives fetch i_valid)
o_cpu_reset  out  1  one-cycle pipeline reset pulse
o_instrmem_addr  out  16  word address for debug write
o_instrmem_data  out  16  halfword write data
o_instrmem_we  out  4  byte-lane write enables: 4'b0011 low half, 4'b1100 high half
o_instrmem_re  out  1  debug read enable, high in IDLE
o_load_done  out  1  one-cycle pulse at load completion
o_running  out  1  high in RUN
o_cycle_count  out  NB_CNT  cycles with o_valid=1 since last o_cpu_reset

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, o_valid 0, o_cpu_reset 0, addr 0, data 0, we 0, o_instrmem_re 0, o_load_done 0, o_running 0, count 0, word/byte counters 0.
- States: IDLE, LOAD, RUN, STEP.

IDLE:
- Responds to bytes on i_rx_valid:
  - 0x4C 'L' -> LOAD; word counter := 0, byte phase := 0.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - any other byte is ignored.
- o_instrmem_re = 1.

LOAD:
- Every byte is data; command codes are not decoded.
- Bytes arrive little-endian: bytes 0 and 1 form the low halfword, bytes 2 and 3 the high halfword.
- After byte 1, in the next cycle, for exactly one cycle: addr = word counter, data = {b1,b0}, we = 4'b0011.
- After byte 3, in the next cycle, for exactly one cycle: data = {b3,b2}, we = 4'b1100; word counter then increments.
- we = 0 in every other cycle.
- Sentinel detection: the low half is flagged if it equals HALT_WORD[15:0]. A sentinel is a flagged low half plus a high half equal to HALT_WORD[31:16].
- Load completes when, after the high-half write:
  - the word was the sentinel, or
  - the word counter was N_ADDR-1.
- On completion, in the cycle after the final write:
  - o_load_done = 1 and o_cpu_reset = 1 for one cycle;
  - count := 0;
  - state -> IDLE.

RUN:
- o_valid = 1 and o_running = 1 starting the cycle after 'R' is received.
- Exits to IDLE, with o_valid dropping the next cycle, on either:
  - i_halt = 1, or
  - rx byte 0x48 'H'.
- Both exit conditions in the same cycle give a single exit.
- Other rx bytes are ignored.

STEP:
- o_valid = 1 for exactly one cycle, starting the cycle after 'S'; then IDLE.
- An i_halt arriving during STEP has no extra effect.

Counter:
- o_cycle_count increments each cycle o_valid = 1.
- Saturates at all-ones.
- Cleared by i_reset or on load completion.

Boundaries:
- A partial word at i_reset is discarded; halfwords already written stay in memory.
- i_rx_valid during a write cycle is accepted and counted as the next byte.
- Words beyond N_ADDR are never addressed.
- A write is never issued outside LOAD.
- i_reset overrides everything in the same cycle.

Test Plan:
- Reset, then 'L' followed by bytes 78 56 34 12 then FF FF FF FF:
  - writes (0, 5678, 0011), (0, 1234, 1100), (1, FFFF, 0011), (1, FFFF, 1100);
  - o_load_done and o_cpu_reset pulse once; state IDLE.
- Load with low half FFFF, high half 0000 -> no termination; the next word goes to addr+1.
- 'R', then i_halt at the 10th valid cycle -> o_valid high for exactly 10 cycles, o_cycle_count = 10; then 'R' again -> count continues from 10.
- Three 'S' bytes spaced 5 cycles apart -> three one-cycle o_valid pulses, count = 3; 'X' in IDLE is ignored.
- Load with no sentinel and N_ADDR = 4 (16 data bytes) -> last write at addr 3 with we 1100, then done; 17th byte ignored as a command.
- i_reset after 3 bytes of a load -> only the low-half write of word 0 occurred; state IDLE, counters 0; new 'L' restarts at addr 0.
